// File: rtl/hazard_pkg.sv
// Shared decode definitions for the hazard/forwarding unit: field positions,
// opcode classes and the in-flight history entry.
package hazard_pkg;

    localparam int OPC_BITS  = 5;
    // History entries carry a fixed-width register tag; the top's RA_W must not exceed it.
    localparam int HIST_RA_W = 8;

    // Field positions in units of RA_W, counted from the LSB of the instruction.
    localparam int RD_FIELD  = 2;
    localparam int RS1_FIELD = 1;
    localparam int RS2_FIELD = 0;

    localparam logic [OPC_BITS-1:0] OPC_LOAD     = 5'b10100;
    localparam logic [OPC_BITS-1:0] OPC_STORE    = 5'b10101;
    localparam logic [OPC_BITS-1:0] OPC_NOWB_0   = 5'b11000;
    localparam logic [2:0]          OPC_NOWB_GRP = 3'b111;

    typedef struct packed {
        logic [HIST_RA_W-1:0] rd;
        logic                 wb;
        logic                 ld;
    } hist_t;

    function automatic logic is_imm(input logic [OPC_BITS-1:0] opc);
        return opc[4:3] == 2'b01;
    endfunction

    function automatic logic is_load(input logic [OPC_BITS-1:0] opc);
        return opc == OPC_LOAD;
    endfunction

    function automatic logic is_store(input logic [OPC_BITS-1:0] opc);
        return opc == OPC_STORE;
    endfunction

    function automatic logic writes_back(input logic [OPC_BITS-1:0] opc);
        return !((opc == OPC_NOWB_0) || (opc[4:2] == OPC_NOWB_GRP) || is_store(opc));
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_match.sv
// Priority comparator of one source register against the in-flight history;
// the youngest writing stage wins.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic [RA_W-1:0]  src_i,
    input  hist_t [DEPTH:1]  hist_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             hit_stage1_load_o
);

    logic ld_near;

    // Scanning oldest to youngest lets the last hit be the nearest producer.
    always_comb begin
        sel_o   = '0;
        ld_near = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if ((src_i != '0) && hist_i[k].wb && (hist_i[k].rd == HIST_RA_W'(src_i))) begin
                sel_o   = SEL_W'(k);
                ld_near = hist_i[k].ld;
            end
        end
        hit_stage1_load_o = ld_near && (sel_o == SEL_W'(1));
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-stage dependency checker: registers the decoded instruction, tracks
// recent destinations for forwarding and inserts one bubble on load-use.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int INS_W = 20,
    parameter int OPC_W = 5,
    parameter int RA_W  = 5,
    parameter int IMM_W = 8,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    output logic [OPC_W-1:0] op_dec,
    output logic             imm_sel,
    output logic [IMM_W-1:0] imm,
    output logic             mem_en_dec,
    output logic             mem_rw_dec,
    output logic             mem_mux_sel_dec,
    output logic [RA_W-1:0]  RW_dec,
    output logic             rw_valid,
    output logic [SEL_W-1:0] mux_sel_A,
    output logic [SEL_W-1:0] mux_sel_B
);

    localparam int RD_LSB  = RD_FIELD * RA_W;
    localparam int RS1_LSB = RS1_FIELD * RA_W;
    localparam int RS2_LSB = RS2_FIELD * RA_W;

    logic [OPC_W-1:0]    opc;
    logic [OPC_BITS-1:0] opc_cls;
    logic [RA_W-1:0]     rd, rs1, rs2;
    logic                cls_imm, cls_load, cls_store, wb_new;
    logic [SEL_W-1:0]    sel_a, sel_b;
    logic                ld_hit_a, ld_hit_b;
    logic                hazard, accept;

    hist_t [DEPTH:1] hist_q, hist_d;

    logic [OPC_W-1:0] op_q;
    logic             imm_sel_q;
    logic [IMM_W-1:0] imm_q;
    logic             mem_en_q, mem_rw_q, mem_mux_q;
    logic [RA_W-1:0]  rw_q;
    logic             rw_valid_q;
    logic [SEL_W-1:0] sel_a_q, sel_b_q;

    assign opc     = ins[INS_W-1 -: OPC_W];
    assign opc_cls = opc[OPC_W-1 -: OPC_BITS];
    assign rd      = ins[RD_LSB  +: RA_W];
    assign rs1     = ins[RS1_LSB +: RA_W];
    assign rs2     = ins[RS2_LSB +: RA_W];

    assign cls_imm   = is_imm(opc_cls);
    assign cls_load  = is_load(opc_cls);
    assign cls_store = is_store(opc_cls);
    assign wb_new    = writes_back(opc_cls) && (rd != '0);

    fwd_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd_a (
        .src_i             (rs1),
        .hist_i            (hist_q),
        .sel_o             (sel_a),
        .hit_stage1_load_o (ld_hit_a)
    );

    fwd_match #(.RA_W(RA_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_fwd_b (
        .src_i             (rs2),
        .hist_i            (hist_q),
        .sel_o             (sel_b),
        .hit_stage1_load_o (ld_hit_b)
    );

    // The rs2 field of an immediate op is not a register read, so it cannot stall.
    assign hazard    = ins_valid && (ld_hit_a || (!cls_imm && ld_hit_b));
    assign ins_ready = !hazard;
    assign accept    = ins_valid && !hazard;

    always_comb begin
        hist_d    = '0;
        if (accept) begin
            hist_d[1].rd = HIST_RA_W'(rd);
            hist_d[1].wb = wb_new;
            hist_d[1].ld = cls_load;
        end
        for (int k = 2; k <= DEPTH; k++) begin
            hist_d[k] = hist_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hist_q     <= '0;
            op_q       <= '0;
            imm_sel_q  <= 1'b0;
            imm_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_mux_q  <= 1'b0;
            rw_q       <= '0;
            rw_valid_q <= 1'b0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
        end else begin
            hist_q <= hist_d;
            if (accept) begin
                op_q       <= opc;
                imm_sel_q  <= cls_imm;
                imm_q      <= IMM_W'(rs2);
                mem_en_q   <= cls_load || cls_store;
                mem_rw_q   <= cls_store;
                mem_mux_q  <= cls_load;
                rw_q       <= rd;
                rw_valid_q <= wb_new;
                sel_a_q    <= sel_a;
                sel_b_q    <= cls_imm ? '0 : sel_b;
            end else begin
                op_q       <= '0;
                imm_sel_q  <= 1'b0;
                imm_q      <= '0;
                mem_en_q   <= 1'b0;
                mem_rw_q   <= 1'b0;
                mem_mux_q  <= 1'b0;
                rw_q       <= '0;
                rw_valid_q <= 1'b0;
                sel_a_q    <= '0;
                sel_b_q    <= '0;
            end
        end
    end

    assign op_dec          = op_q;
    assign imm_sel         = imm_sel_q;
    assign imm             = imm_q;
    assign mem_en_dec      = mem_en_q;
    assign mem_rw_dec      = mem_rw_q;
    assign mem_mux_sel_dec = mem_mux_q;
    assign RW_dec          = rw_q;
    assign rw_valid        = rw_valid_q;
    assign mux_sel_A       = sel_a_q;
    assign mux_sel_B       = sel_b_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed vector bench for hazard_fwd_unit with a hand-written reset-during-stall sequence.
module tb_hazard_fwd_unit;

    localparam logic [4:0] ADD  = 5'b00001;
    localparam logic [4:0] ADDI = 5'b01000;
    localparam logic [4:0] ORI  = 5'b01001;
    localparam logic [4:0] LD   = 5'b10100;
    localparam logic [4:0] ST   = 5'b10101;
    localparam logic [4:0] NW0  = 5'b11000;
    localparam logic [4:0] NW7  = 5'b11100;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [4:0]  op_dec;
    logic        imm_sel;
    logic [7:0]  imm;
    logic        mem_en_dec, mem_rw_dec, mem_mux_sel_dec;
    logic [4:0]  RW_dec;
    logic        rw_valid;
    logic [1:0]  mux_sel_A, mux_sel_B;

    int total = 0;
    int bad   = 0;
    int vi    = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ins             (ins),
        .ins_valid       (ins_valid),
        .ins_ready       (ins_ready),
        .op_dec          (op_dec),
        .imm_sel         (imm_sel),
        .imm             (imm),
        .mem_en_dec      (mem_en_dec),
        .mem_rw_dec      (mem_rw_dec),
        .mem_mux_sel_dec (mem_mux_sel_dec),
        .RW_dec          (RW_dec),
        .rw_valid        (rw_valid),
        .mux_sel_A       (mux_sel_A),
        .mux_sel_B       (mux_sel_B)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [19:0] ins;
        logic        rdy;
        logic        full;   // 0: bubble, RW_dec/imm/imm_sel are don't-care
        logic [4:0]  op;
        logic        isel;
        logic [7:0]  imm;
        logic [2:0]  mem;    // {mem_en, mem_rw, mem_mux_sel}
        logic [4:0]  rw;
        logic        rwv;
        logic [1:0]  sa;
        logic [1:0]  sb;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] mk(input logic [4:0] o, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {o, rd, rs1, rs2};
    endfunction

    task automatic add(input logic rst, input logic vld, input logic [19:0] i, input logic rdy,
                       input logic [4:0] op, input logic isel, input logic [7:0] im,
                       input logic [2:0] mem, input logic [4:0] rw, input logic rwv,
                       input logic [1:0] sa, input logic [1:0] sb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.ins = i; v.rdy = rdy; v.full = 1'b1;
        v.op = op; v.isel = isel; v.imm = im; v.mem = mem; v.rw = rw; v.rwv = rwv;
        v.sa = sa; v.sb = sb;
        vecs.push_back(v);
    endtask

    task automatic bub(input logic vld, input logic [19:0] i, input logic rdy);
        vec_t v;
        v = '{rst: 1'b1, vld: vld, ins: i, rdy: rdy, full: 1'b0, op: 5'd0, isel: 1'b0,
              imm: 8'd0, mem: 3'b000, rw: 5'd0, rwv: 1'b0, sa: 2'd0, sb: 2'd0};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, vi, act, exp);
        end
    endtask

    initial begin
        // reset held with traffic present
        add(0, 1, mk(ADD, 3, 1, 2),   1, 5'd0, 0, 8'h00, 3'b000, 5'd0, 0, 0, 0);
        add(0, 1, mk(ADD, 3, 1, 2),   1, 5'd0, 0, 8'h00, 3'b000, 5'd0, 0, 0, 0);
        add(1, 1, mk(ADD, 3, 1, 2),   1, ADD,  0, 8'h02, 3'b000, 5'd3, 1, 0, 0);
        // back-to-back dependency
        add(1, 1, mk(ADD, 4, 3, 3),   1, ADD,  0, 8'h03, 3'b000, 5'd4, 1, 1, 1);
        // distance 3, then aged out
        add(1, 1, mk(ADD, 5, 1, 2),   1, ADD,  0, 8'h02, 3'b000, 5'd5, 1, 0, 0);
        add(1, 1, mk(ADD, 10, 1, 2),  1, ADD,  0, 8'h02, 3'b000, 5'd10, 1, 0, 0);
        add(1, 1, mk(ADD, 11, 1, 2),  1, ADD,  0, 8'h02, 3'b000, 5'd11, 1, 0, 0);
        add(1, 1, mk(ADD, 12, 5, 1),  1, ADD,  0, 8'h01, 3'b000, 5'd12, 1, 3, 0);
        add(1, 1, mk(ADD, 13, 5, 1),  1, ADD,  0, 8'h01, 3'b000, 5'd13, 1, 0, 0);
        // load-use on rs1: one bubble, then forward from stage 2
        add(1, 1, mk(LD, 6, 1, 2),    1, LD,   0, 8'h02, 3'b101, 5'd6, 1, 0, 0);
        bub(1, mk(ADD, 7, 6, 1), 0);
        add(1, 1, mk(ADD, 7, 6, 1),   1, ADD,  0, 8'h01, 3'b000, 5'd7, 1, 2, 0);
        // nearest producer wins; r0 and store are never forwarded
        add(1, 1, mk(ADD, 2, 1, 1),   1, ADD,  0, 8'h01, 3'b000, 5'd2, 1, 0, 0);
        add(1, 1, mk(ADD, 2, 1, 1),   1, ADD,  0, 8'h01, 3'b000, 5'd2, 1, 0, 0);
        add(1, 1, mk(ADD, 8, 2, 2),   1, ADD,  0, 8'h02, 3'b000, 5'd8, 1, 1, 1);
        add(1, 1, mk(ADD, 0, 1, 1),   1, ADD,  0, 8'h01, 3'b000, 5'd0, 0, 0, 0);
        add(1, 1, mk(ADD, 14, 0, 0),  1, ADD,  0, 8'h00, 3'b000, 5'd14, 1, 0, 0);
        add(1, 1, mk(ST, 9, 1, 2),    1, ST,   0, 8'h02, 3'b110, 5'd9, 0, 0, 0);
        add(1, 1, mk(ADD, 15, 9, 9),  1, ADD,  0, 8'h09, 3'b000, 5'd15, 1, 0, 0);
        // immediate class ignores rs2 matches
        add(1, 1, mk(ADD, 31, 1, 1),  1, ADD,  0, 8'h01, 3'b000, 5'd31, 1, 0, 0);
        add(1, 1, mk(ADDI, 16, 1, 31), 1, ADDI, 1, 8'h1F, 3'b000, 5'd16, 1, 0, 0);
        // no-writeback opcode groups
        add(1, 1, mk(NW7, 17, 16, 1), 1, NW7,  0, 8'h01, 3'b000, 5'd17, 0, 1, 0);
        add(1, 1, mk(ADD, 18, 17, 31), 1, ADD, 0, 8'h1F, 3'b000, 5'd18, 1, 0, 3);
        add(1, 1, mk(NW0, 19, 1, 1),  1, NW0,  0, 8'h01, 3'b000, 5'd19, 0, 0, 0);
        add(1, 1, mk(ADD, 20, 19, 18), 1, ADD, 0, 8'h12, 3'b000, 5'd20, 1, 0, 2);
        // idle cycle is a bubble
        bub(0, mk(ADD, 21, 20, 20), 1);
        add(1, 1, mk(ADD, 22, 20, 1), 1, ADD,  0, 8'h01, 3'b000, 5'd22, 1, 2, 0);
        // load-use on rs2
        add(1, 1, mk(LD, 23, 1, 1),   1, LD,   0, 8'h01, 3'b101, 5'd23, 1, 0, 0);
        bub(1, mk(ADD, 24, 1, 23), 0);
        add(1, 1, mk(ADD, 24, 1, 23), 1, ADD,  0, 8'h17, 3'b000, 5'd24, 1, 0, 2);
        // immediate after load with matching rs2 field: no stall
        add(1, 1, mk(LD, 25, 1, 1),   1, LD,   0, 8'h01, 3'b101, 5'd25, 1, 0, 0);
        add(1, 1, mk(ORI, 26, 1, 25), 1, ORI,  1, 8'h19, 3'b000, 5'd26, 1, 0, 0);
        // invalid slot hides the hazard, consumer then forwards from stage 2
        add(1, 1, mk(LD, 27, 1, 1),   1, LD,   0, 8'h01, 3'b101, 5'd27, 1, 0, 0);
        bub(0, mk(ADD, 28, 27, 1), 1);
        add(1, 1, mk(ADD, 28, 27, 1), 1, ADD,  0, 8'h01, 3'b000, 5'd28, 1, 2, 0);

        reset = 1'b0; ins_valid = 1'b0; ins = '0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vi        = i;
            reset     = vecs[i].rst;
            ins_valid = vecs[i].vld;
            ins       = vecs[i].ins;
            #1;
            chk("ins_ready", ins_ready, vecs[i].rdy);
            @(posedge clk); #1;
            chk("op_dec",   op_dec, vecs[i].op);
            chk("mem",      {mem_en_dec, mem_rw_dec, mem_mux_sel_dec}, vecs[i].mem);
            chk("rw_valid", rw_valid, vecs[i].rwv);
            chk("sel_A",    mux_sel_A, vecs[i].sa);
            chk("sel_B",    mux_sel_B, vecs[i].sb);
            if (vecs[i].full) begin
                chk("imm_sel", imm_sel, vecs[i].isel);
                chk("imm",     imm, vecs[i].imm);
                chk("RW_dec",  RW_dec, vecs[i].rw);
            end
        end

        // reset while a load-use stall is pending
        vi = 1000;
        reset = 1'b1; ins_valid = 1'b1; ins = mk(LD, 6, 1, 1);
        @(posedge clk); #1;
        ins = mk(ADD, 7, 6, 1);
        #1;
        chk("stall_ready", ins_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", ins_ready, 1'b1);
        chk("rst_outs", {op_dec, imm_sel, imm, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
                         RW_dec, rw_valid, mux_sel_A, mux_sel_B}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_op",  op_dec, ADD);
        chk("post_rst_rw",  RW_dec, 5'd7);
        chk("post_rst_selA", mux_sel_A, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised decode-stage dependency checker for the pipelined core.
- Decodes the incoming instruction and tracks the destination registers of the last DEPTH in-flight instructions, with valid and write-back qualification.
- Generates operand forwarding selects and memory control.
- Inserts a single-cycle load-use interlock bubble through a ready/valid handshake with fetch.
- Outputs feed the ALU operand muxes and the memory stage.

Parameters:
INS_W, 20, instruction width; must be >= OPC_W+3*RA_W
OPC_W, 5, opcode width, field ins[INS_W-1 -: OPC_W]
RA_W, 5, register address width
IMM_W, 8, immediate output width; zero-extended from the rs2 field
DEPTH, 3, number of tracked in-flight stages, >=1
SEL_W, $clog2(DEPTH+1), forwarding select width (derived)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-low; 0 at a posedge clears all state
ins  in  INS_W  instruction: opcode | rd [3RA_W-1:2RA_W] | rs1 [2RA_W-1:RA_W] | rs2/imm [RA_W-1:0]
ins_valid  in  1  ins is meaningful this cycle
ins_ready  out  1  combinational; 0 during load-use stall, fetch must hold ins
op_dec  out  OPC_W  registered opcode; 0 (NOP) for bubbles
imm_sel  out  1  operand B is the immediate
imm  out  IMM_W  zero-extended rs2 field
mem_en_dec  out  1  load or store
mem_rw_dec  out  1  1 = store, 0 = load
mem_mux_sel_dec  out  1  write-back from memory (load)
RW_dec  out  RA_W  destination register
rw_valid  out  1  instruction writes RW_dec
mux_sel_A  out  SEL_W  0 = register file; k = forward from history stage k (1 = youngest)
mux_sel_B  out  SEL_W  same encoding, operand B

Behaviour:
- Opcode classes (package functions):
  - imm: opc[4:3]=01
  - load: 10100
  - store: 10101
  - no-writeback: 11000, 111xx, store
  - wb = valid & ~no-writeback & rd!=0
- Accept = ins_valid & ins_ready. All outputs are registered, with 1-cycle latency from accept.
- History: shift register H[1..DEPTH] of {rd, wb, is_load}; it shifts every non-reset cycle.
  - H[1] <= the accepted instruction, or a bubble (wb=0, is_load=0) when not accepted.
- Forwarding: for each source (rs1 → A; rs2 → B unless imm class), sel = smallest k with H[k].wb and H[k].rd == src, else 0.
  - src==0 always gives 0.
  - Imm-class gives mux_sel_B = 0.
- Load-use hazard (combinational): ins_valid & H[1].is_load & H[1].wb & (rs1 match H[1], or rs2 match H[1] for non-imm).
  - ins_ready = ~hazard.
  - The stalled cycle registers a bubble: op_dec=0, rw_valid=0, mem_* = 0, sel = 0.
  - Next cycle the load sits in H[2]; the instruction is accepted with sel=2. Exactly one bubble per load-use.
- ins_valid=0: registers a bubble; ins_ready=1.
- Reset: every output register and all H entries go to 0; ins_ready=1 on the first cycle after reset. Reset during a stall discards the stalled instruction's pending state.
- Aging: a producer older than DEPTH is not forwarded; sel=0 and the value comes from the register file.

Decomposition:
- Package hazard_pkg holds:
  - field-offset localparams
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_NOWB_0, OPC_NOWB_GRP)
  - functions is_imm, is_load, is_store, writes_back
  - history-entry struct
- Sub-module fwd_match: a parametrised priority comparator (src, H vector → sel, hit_stage1_load), instantiated once per operand.

Test Plan:
1. reset=0 for 2 cycles with valid ADD traffic → all outputs 0, ins_ready=1. Release → the first ADD decodes with sel A=B=0.
2. ADD r3,r1,r2 then ADD r4,r3,r3 back-to-back → second decode mux_sel_A=1, mux_sel_B=1, RW_dec=4, rw_valid=1.
3. Write r5, two unrelated ops, read r5 as A → mux_sel_A=3. One more unrelated op, then read r5 → 0 (aged out).
4. LD r6 (10100), then ADD r7,r6,r1 → ins_ready=0 for 1 cycle. Bubble has op_dec=0, mem_en_dec=0. Next cycle ADD has mux_sel_A=2. The load decode has mem_en=1, mem_rw=0, mem_mux_sel=1.
5. Two producers of r2 at distances 1 and 2 → sel=1. A write to r0 then a read of r0 → sel=0. A store whose rd field is r9, then a read of r9 → sel=0.
6. Imm op with rs2 field 5'h1F while r31 is in H[1] → imm_sel=1, imm=8'h1F, mux_sel_B=0. Assert reset during a load-use stall → next cycle all outputs 0 and ins_ready=1.
